// File: rtl/pfc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pfc_pkg
// Description : Shared constants and types for the vectored program-flow
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pfc_pkg;

    localparam int c_RESET_ADDR = 'h0000;
    localparam int c_VEC_BASE   = 'h0004;
    localparam int c_VEC_STRIDE = 2;

    // Where the next PC comes from on a non-stalled edge
    typedef enum logic [1:0] {
        PFC_SEQ = 2'd0,
        PFC_BR  = 2'd1,
        PFC_VEC = 2'd2,
        PFC_RET = 2'd3
    } pfc_src_e;

endpackage : pfc_pkg
`default_nettype wire

// File: rtl/pfc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : pfc_prio_enc
// Description : Priority encoder, lowest set index wins; returns valid, the
//               binary index and the matching one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module pfc_prio_enc #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    output logic           o_valid,
    output logic [IDW-1:0] o_id,
    output logic [N-1:0]   o_onehot
);

    always_comb begin
        o_valid  = 1'b0;
        o_id     = '0;
        o_onehot = '0;
        // Scan high to low so the lowest set index is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid     = 1'b1;
                o_id        = IDW'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule : pfc_prio_enc
`default_nettype wire

// File: rtl/pfc_vec.sv
`default_nettype none
// ============================================================================
// Module      : pfc_vec
// Description : Program-flow controller with PC, conditional branch, and
//               vectored priority interrupts with return-from-interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module pfc_vec
    import pfc_pkg::*;
#(
    parameter  int              XLEN       = 16,
    parameter  int              N_INTR     = 4,
    parameter  logic [XLEN-1:0] RESET_ADDR = XLEN'(c_RESET_ADDR),
    parameter  logic [XLEN-1:0] VEC_BASE   = XLEN'(c_VEC_BASE),
    parameter  int              VEC_STRIDE = c_VEC_STRIDE,
    localparam int              IDW        = (N_INTR > 1) ? $clog2(N_INTR) : 1
) (
    input  logic              clk_pc,
    input  logic              rst,
    input  logic              stall,
    input  logic [XLEN-1:0]   cond,
    input  logic [XLEN-1:0]   alu,
    input  logic              pfc_ctrl,
    input  logic              reti,
    input  logic              ie_wr,
    input  logic              ie_wdata,
    input  logic [N_INTR-1:0] intr_req,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_inc,
    output logic [XLEN-1:0]   intr_ra,
    output logic              intr_ie,
    output logic              intr_active,
    output logic [IDW-1:0]    intr_id,
    output logic [N_INTR-1:0] intr_ack,
    output logic [N_INTR-1:0] intr_pend
);

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_ra;
    logic              r_ie;
    logic              r_active;
    logic [IDW-1:0]    r_id;
    logic [N_INTR-1:0] r_pend;
    logic [N_INTR-1:0] r_req_q;

    logic              w_enc_valid;
    logic [IDW-1:0]    w_enc_id;
    logic [N_INTR-1:0] w_enc_oh;
    logic              w_br_taken;
    logic              w_can_take;
    logic              w_take;
    logic [XLEN-1:0]   w_pc_inc;
    logic [XLEN-1:0]   w_next_pc;
    logic [XLEN-1:0]   w_vec;
    logic [N_INTR-1:0] w_ack;
    logic [N_INTR-1:0] w_rise;
    pfc_src_e          w_src;

    logic [XLEN-1:0]   w_pc_d;
    logic [XLEN-1:0]   w_ra_d;
    logic              w_ie_d;
    logic              w_act_d;
    logic [IDW-1:0]    w_id_d;

    pfc_prio_enc #(
        .N (N_INTR)
    ) u_prio_enc (
        .i_req    (r_pend),
        .o_valid  (w_enc_valid),
        .o_id     (w_enc_id),
        .o_onehot (w_enc_oh)
    );

    assign w_pc_inc   = r_pc + XLEN'(1);
    assign w_br_taken = pfc_ctrl && (cond == '0);
    assign w_next_pc  = w_br_taken ? alu : w_pc_inc;
    assign w_vec      = VEC_BASE + XLEN'(w_enc_id) * XLEN'(VEC_STRIDE);
    assign w_can_take = r_ie && !r_active && w_enc_valid;

    always_comb begin
        w_src = PFC_SEQ;
        if (reti) begin
            w_src = PFC_RET;
        end else if (w_can_take) begin
            w_src = PFC_VEC;
        end else if (w_br_taken) begin
            w_src = PFC_BR;
        end
    end

    assign w_take = !stall && (w_src == PFC_VEC);
    assign w_ack  = w_take ? w_enc_oh : '0;
    assign w_rise = intr_req & ~r_req_q;

    always_comb begin
        w_pc_d  = w_next_pc;
        w_ra_d  = r_ra;
        w_ie_d  = r_ie;
        w_act_d = r_active;
        w_id_d  = r_id;
        case (w_src)
            PFC_RET: begin
                w_pc_d  = r_ra;
                w_ie_d  = 1'b1;
                w_act_d = 1'b0;
            end
            PFC_VEC: begin
                w_pc_d  = w_vec;
                w_ra_d  = w_next_pc;
                w_id_d  = w_enc_id;
                w_ie_d  = 1'b0;
                w_act_d = 1'b1;
            end
            default: begin
                if (ie_wr) begin
                    w_ie_d = ie_wdata;
                end
            end
        endcase
    end

    // Edge capture runs through stalls; a new edge outranks the ack clear
    always_ff @(posedge clk_pc or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_ADDR;
            r_ra     <= '0;
            r_ie     <= 1'b0;
            r_active <= 1'b0;
            r_id     <= '0;
            r_pend   <= '0;
            r_req_q  <= '0;
        end else begin
            r_req_q <= intr_req;
            r_pend  <= (r_pend & ~w_ack) | w_rise;
            if (!stall) begin
                r_pc     <= w_pc_d;
                r_ra     <= w_ra_d;
                r_ie     <= w_ie_d;
                r_active <= w_act_d;
                r_id     <= w_id_d;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_inc      = w_pc_inc;
    assign intr_ra     = r_ra;
    assign intr_ie     = r_ie;
    assign intr_active = r_active;
    assign intr_id     = r_id;
    assign intr_pend   = r_pend;
    assign intr_ack    = rst ? '0 : w_ack;

endmodule : pfc_vec
`default_nettype wire
